// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations each, sign fixed up at the end.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  MDCode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WrHI,
    input  logic        WrLO,
    input  logic [31:0] WrData,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        DivZero
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state;
    logic [1:0]  op;
    logic [31:0] acc;
    logic [31:0] mq;
    logic [31:0] opb;
    logic [4:0]  count;
    logic        neg_q;
    logic        neg_r;
    logic        zero_div;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [31:0] mq_abs;
    logic [31:0] opb_abs;
    logic [63:0] product;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign mul_sum   = {1'b0, acc} + {1'b0, opb};
    assign div_shift = {acc, mq[31]};
    // Partial remainder is always < 2*divisor, so bit 32 of the trial is the borrow.
    assign div_trial = div_shift - {1'b0, opb};
    assign mq_abs    = mq[31]  ? (32'd0 - mq)  : mq;
    assign opb_abs   = opb[31] ? (32'd0 - opb) : opb;
    assign product   = {acc, mq};
    assign prod_fix  = neg_q ? (64'd0 - product) : product;
    assign quot_fix  = neg_q ? (32'd0 - mq)  : mq;
    assign rem_fix   = neg_r ? (32'd0 - acc) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op       <= '0;
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (WrHI) HI <= WrData;
                    if (WrLO) LO <= WrData;
                    if (start) begin
                        op    <= MDCode;
                        mq    <= A;
                        opb   <= B;
                        busy  <= 1'b1;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    acc      <= '0;
                    count    <= '0;
                    zero_div <= op[1] && (opb == 32'd0);
                    if (!op[0]) begin
                        mq    <= mq_abs;
                        opb   <= opb_abs;
                        neg_q <= mq[31] ^ opb[31];
                        neg_r <= mq[31];
                    end else begin
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!op[1]) begin
                        if (mq[0]) {acc, mq} <= {mul_sum, mq[31:1]};
                        else       {acc, mq} <= {1'b0, acc, mq[31:1]};
                    end else begin
                        if (!div_trial[32]) begin
                            acc <= div_trial[31:0];
                            mq  <= {mq[30:0], 1'b1};
                        end else begin
                            acc <= div_shift[31:0];
                            mq  <= {mq[30:0], 1'b0};
                        end
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!op[1]) begin
                        {HI, LO} <= prod_fix;
                    end else if (!zero_div) begin
                        LO <= quot_fix;
                        HI <= rem_fix;
                    end
                    done    <= 1'b1;
                    DivZero <= zero_div;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    DivZero <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver queues expected results, a forked monitor
// checks HI/LO/DivZero and done timing whenever done is seen.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  MDCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        WrHI;
    logic        WrLO;
    logic [31:0] WrData;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        DivZero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc;
    int          checks;
    int          passes;

    muldiv_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDCode  (MDCode),
        .A       (A),
        .B       (B),
        .WrHI    (WrHI),
        .WrLO    (WrLO),
        .WrData  (WrData),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done),
        .DivZero (DivZero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want)
            $display("FAIL %s: got %h, expected %h", name, got, want);
        else
            passes++;
    endtask

    // Issue one operation; inject>0 fires a second start plus WrHI during the run.
    task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int inject, input bit wrlo_same);
        exp_t e;
        int   n;
        @(negedge clk);
        MDCode = code;
        A      = a;
        B      = b;
        start  = 1'b1;
        if (wrlo_same) begin
            WrLO   = 1'b1;
            WrData = 32'h0000AAAA;
        end
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.cyc = cyc + 35;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        WrLO   = 1'b0;
        A      = $urandom;
        B      = $urandom;
        MDCode = 2'($urandom_range(0, 3));
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (wrlo_same) check("wrlo_same_cycle", LO, 32'h0000AAAA);
        n = 1;
        for (int k = 0; k < 60 && busy; k++) begin
            @(negedge clk);
            start = 1'b0;
            WrHI  = 1'b0;
            if (busy) n++;
            if (n == inject) begin
                start  = 1'b1;
                MDCode = 2'b01;
                A      = 32'd2;
                B      = 32'd2;
                WrHI   = 1'b1;
                WrData = 32'h0000DEAD;
            end
        end
        start = 1'b0;
        WrHI  = 1'b0;
        check("busy_len", n, 35);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cyc    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        MDCode = 2'b00;
        A      = '0;
        B      = '0;
        WrHI   = 1'b0;
        WrLO   = 1'b0;
        WrData = '0;

        fork
            forever begin
                @(negedge clk);
                if (!reset && DivZero && !done) begin
                    checks++;
                    $display("FAIL divzero_no_done: DivZero=1 done=0, expected DivZero only with done");
                end
                if (!reset && done) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_done: done=1, expected no pending result");
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("hi", HI, e.hi);
                        check("lo", LO, e.lo);
                        check("divzero", {31'd0, DivZero}, {31'd0, e.dz});
                        check("done_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_divzero", {31'd0, DivZero}, 32'd0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
        run_op(2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 0, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 0, 1'b0);

        @(negedge clk);
        WrHI   = 1'b1;
        WrData = 32'h00001234;
        @(negedge clk);
        WrHI   = 1'b0;
        WrLO   = 1'b1;
        WrData = 32'h00005678;
        @(negedge clk);
        WrLO   = 1'b0;
        check("preload_hi", HI, 32'h00001234);
        check("preload_lo", LO, 32'h00005678);
        run_op(2'b11, 32'd9, 32'd0, 32'h00001234, 32'h00005678, 1'b1, 0, 1'b0);

        run_op(2'b00, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFED4, 1'b0, 5, 1'b0);
        run_op(2'b11, 32'd100, 32'd7,        32'd2,        32'd14,       1'b0, 0, 1'b1);

        @(negedge clk);
        MDCode = 2'b00;
        A      = 32'd5;
        B      = 32'd6;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
